// File: rtl/test_pattern_sched_pkg.sv
// -----------------------------------------------------------------------------
// test_pattern_pkg
// Shared types and default widths for the MAC link test-pattern scheduler and
// the timestamp block that it shares with the receive checker.
//
// Contents:
//   DEF_*          default parameter values for the scheduler and timestamp
//   IDX_WIDTH      width of the generator packet_index (fixed)
//   sched_state_e  scheduler state encoding
//   is_gen_state   true in the states where the generator is enabled
// -----------------------------------------------------------------------------
package test_pattern_pkg;

  localparam int DEF_TS_WIDTH    = 24;
  localparam int DEF_TS_PRESCALE = 1;
  localparam int DEF_GAP_WIDTH   = 16;
  localparam int DEF_CNT_WIDTH   = 32;
  localparam int IDX_WIDTH       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } sched_state_e;

  function automatic logic is_gen_state(input sched_state_e s);
    return (s == ST_ARM) || (s == ST_SEND);
  endfunction

endpackage

// File: rtl/test_pattern_sched_timestamp.sv
// -----------------------------------------------------------------------------
// test_pattern_timestamp
// Free-running timestamp: a prescaler divides clk by TS_PRESCALE and the
// counter advances once per prescaler period, wrapping modulo 2^TS_WIDTH.
// Only rst stops it. Reusable on the receive-checker side so both ends share
// the same time base.
//
// Parameters:
//   TS_WIDTH     counter width
//   TS_PRESCALE  clk cycles per increment, 1..65535
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   timestamp  out  current timestamp value
// -----------------------------------------------------------------------------
module test_pattern_timestamp
  import test_pattern_pkg::*;
#(
  parameter int TS_WIDTH    = DEF_TS_WIDTH,
  parameter int TS_PRESCALE = DEF_TS_PRESCALE
) (
  input  logic                clk,
  input  logic                rst,
  output logic [TS_WIDTH-1:0] timestamp
);

  // A prescale of 1 still gets a 1-bit prescaler whose terminal value is 0,
  // so the counter then advances on every cycle.
  localparam int PRE_W = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TS_PRESCALE - 1);

  logic [PRE_W-1:0]    r_pre;
  logic [TS_WIDTH-1:0] r_ts;
  logic                w_tick;

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_ts  <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_ts  <= r_ts + TS_WIDTH'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign timestamp = r_ts;

endmodule

// File: rtl/test_pattern_sched.sv
// -----------------------------------------------------------------------------
// test_pattern_sched
// Sequences the MAC test-pattern generator: issues cfg_packet_count packets
// (0 = unlimited) separated by cfg_gap_cycles idle cycles, tracks packet start
// and completion from the generator handshakes, and owns the shared
// free-running timestamp.
//
// State table:
//   state | meaning
//   IDLE  | no run; waiting for an accepted start
//   ARM   | generator enabled, waiting for the header handshake
//   SEND  | header accepted, waiting for the payload tlast handshake
//   GAP   | generator disabled for max(gap,1) cycles, then re-arm or finish
//
// Optional build macro TEST_PATTERN_SCHED_TIMEOUT_EN:
//   adds parameter TIMEOUT_CYCLES and output timeout_err. A watchdog, reloaded
//   on every entry to ARM or SEND, forces IDLE (with done) when a packet
//   stalls for TIMEOUT_CYCLES cycles. timeout_err is sticky until rst or an
//   accepted start. Without the macro ARM/SEND wait indefinitely.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, stop       run start pulse, graceful stop request pulse
//   cfg_packet_count  packets per run (0 = unlimited), sampled on start
//   cfg_gap_cycles    idle cycles between packets, sampled on start
//   gen_enable        generator enable (ARM or SEND)
//   packet_index      index of the current packet
//   timestamp         shared free-running timestamp
//   gen_hdr_fire      generator header valid && ready
//   gen_last_fire     generator payload tvalid && tready && tlast
//   busy              run in progress
//   done              one-cycle pulse when a run ends
//   sent_count        packets completed in the current or last run
//   timeout_err       (macro only) sticky watchdog flag
// -----------------------------------------------------------------------------
module test_pattern_sched
  import test_pattern_pkg::*;
#(
  parameter int TS_WIDTH    = DEF_TS_WIDTH,
  parameter int TS_PRESCALE = DEF_TS_PRESCALE,
  parameter int GAP_WIDTH   = DEF_GAP_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
`ifdef TEST_PATTERN_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_WIDTH-1:0] cfg_packet_count,
  input  logic [GAP_WIDTH-1:0] cfg_gap_cycles,
  output logic                 gen_enable,
  output logic [IDX_WIDTH-1:0] packet_index,
  output logic [TS_WIDTH-1:0]  timestamp,
  input  logic                 gen_hdr_fire,
  input  logic                 gen_last_fire,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] sent_count
`ifdef TEST_PATTERN_SCHED_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  sched_state_e         r_state;
  sched_state_e         w_state_nxt;

  logic [CNT_WIDTH-1:0] r_cfg_count;
  logic [GAP_WIDTH-1:0] r_cfg_gap;
  logic [GAP_WIDTH-1:0] r_gap_cnt;
  logic [GAP_WIDTH-1:0] w_gap_load;
  logic [CNT_WIDTH-1:0] r_sent;
  logic [IDX_WIDTH-1:0] r_idx;
  logic                 r_stop_pend;
  logic                 r_done;

  logic                 w_accept_start;
  logic                 w_pkt_done;
  logic                 w_end_run;
  logic                 w_count_reached;

  // Gap down-counter reload: a configured gap of 0 behaves like 1.
  assign w_gap_load = (r_cfg_gap == '0) ? '0 : (r_cfg_gap - GAP_WIDTH'(1));

  assign w_count_reached = (r_cfg_count != '0) && (r_sent == r_cfg_count);

`ifdef TEST_PATTERN_SCHED_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout_err;
  logic            w_wd_expired;
  logic            w_timeout;

  assign w_wd_expired = (r_wd_cnt == '0);
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept_start = 1'b0;
    w_pkt_done     = 1'b0;
    w_end_run      = 1'b0;
`ifdef TEST_PATTERN_SCHED_TIMEOUT_EN
    w_timeout      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        // A start coinciding with stop is dropped.
        if (start && !stop) begin
          w_accept_start = 1'b1;
          w_state_nxt    = ST_ARM;
        end
      end
      ST_ARM: begin
        if (gen_hdr_fire) begin
          w_state_nxt = ST_SEND;
        end
`ifdef TEST_PATTERN_SCHED_TIMEOUT_EN
        else if (w_wd_expired) begin
          w_timeout   = 1'b1;
          w_end_run   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      ST_SEND: begin
        if (gen_last_fire) begin
          w_pkt_done  = 1'b1;
          w_state_nxt = ST_GAP;
        end
`ifdef TEST_PATTERN_SCHED_TIMEOUT_EN
        else if (w_wd_expired) begin
          w_timeout   = 1'b1;
          w_end_run   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      ST_GAP: begin
        if (r_gap_cnt == '0) begin
          // A stop arriving on the expiry cycle itself still ends the run here.
          if (r_stop_pend || stop || w_count_reached) begin
            w_end_run   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_ARM;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run counters, configuration capture, stop latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_count <= '0;
      r_cfg_gap   <= '0;
      r_gap_cnt   <= '0;
      r_sent      <= '0;
      r_idx       <= '0;
      r_stop_pend <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_end_run;

      if (w_accept_start) begin
        r_cfg_count <= cfg_packet_count;
        r_cfg_gap   <= cfg_gap_cycles;
        r_sent      <= '0;
        r_idx       <= '0;
      end

      if (w_pkt_done) begin
        r_sent    <= r_sent + CNT_WIDTH'(1);
        r_idx     <= r_idx + IDX_WIDTH'(1);
        r_gap_cnt <= w_gap_load;
      end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
      end

      if (w_state_nxt == ST_IDLE) begin
        r_stop_pend <= 1'b0;
      end else if ((r_state != ST_IDLE) && stop) begin
        r_stop_pend <= 1'b1;
      end
    end
  end

`ifdef TEST_PATTERN_SCHED_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Watchdog: down-counter reloaded on each entry to ARM or SEND.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((w_state_nxt != r_state) && is_gen_state(w_state_nxt)) begin
        r_wd_cnt <= WD_LOAD;
      end else if (is_gen_state(r_state) && !w_wd_expired) begin
        r_wd_cnt <= r_wd_cnt - WD_W'(1);
      end

      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (w_accept_start) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`endif

  // ---------------------------------------------------------------------------
  // Timestamp
  // ---------------------------------------------------------------------------
  test_pattern_timestamp #(
    .TS_WIDTH    (TS_WIDTH),
    .TS_PRESCALE (TS_PRESCALE)
  ) u_timestamp (
    .clk       (clk),
    .rst       (rst),
    .timestamp (timestamp)
  );

  assign gen_enable   = is_gen_state(r_state);
  assign busy         = (r_state != ST_IDLE);
  assign done         = r_done;
  assign packet_index = r_idx;
  assign sent_count   = r_sent;

endmodule

// File: doc/test_pattern_sched.md
Name: test_pattern_sched

Overview:
Scheduler that sequences the test-pattern generator for MAC link testing. It issues a configured number of test packets at a configured inter-packet gap and drives the generator's enable and packet_index. It also owns the free-running 24-bit timestamp shared by the generator and the receive checker. It observes the generator's header and payload handshakes to detect packet start and completion.

Parameters:
TS_WIDTH, 24, timestamp counter width (matches the checker's time_gap arithmetic)
TS_PRESCALE, 1, clk cycles per timestamp increment; legal range 1..65535
GAP_WIDTH, 16, width of the inter-packet gap configuration
CNT_WIDTH, 32, width of the packet-count configuration and the sent counter
TIMEOUT_CYCLES, 4096, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begin a run
stop  in  1  pulse; graceful stop request
cfg_packet_count  in  CNT_WIDTH  packets per run; 0 = unlimited
cfg_gap_cycles  in  GAP_WIDTH  idle cycles between packets
gen_enable  out  1  enable to the generator
packet_index  out  16  index of the current packet
timestamp  out  TS_WIDTH  free-running timestamp
gen_hdr_fire  in  1  generator header valid&&ready
gen_last_fire  in  1  generator payload tvalid&&tready&&tlast
busy  out  1  run in progress (state != IDLE)
done  out  1  one-cycle pulse when a run ends
sent_count  out  CNT_WIDTH  packets completed in the current or last run

Behaviour:
- Reset: every output 0; state IDLE; prescaler 0.
- Timestamp: increments by 1 each TS_PRESCALE cycles and wraps modulo 2^TS_WIDTH. It runs in every state, including IDLE, and is stopped only by rst.
- cfg_packet_count and cfg_gap_cycles are sampled on an accepted start; changes during a run are ignored.
- The FSM is registered; gen_enable = (state == ARM || state == SEND).
- IDLE: start && !stop -> ARM. Same cycle: sent_count <= 0, packet_index <= 0. A start with stop asserted in the same cycle is dropped.
- ARM: gen_hdr_fire -> SEND.
- SEND: gen_last_fire -> GAP. Same cycle: sent_count += 1, packet_index += 1 (wraps at 16 bits).
- GAP: the gap counter counts max(cfg_gap_cycles, 1) cycles, so a gap of 0 behaves as 1. At expiry:
  - if a stop is pending, or cfg_packet_count != 0 and sent_count == cfg_packet_count -> IDLE with done pulse;
  - else -> ARM.
- stop: latched as stop_pending in any non-IDLE state. It never aborts a packet; the run ends at the next GAP expiry. stop_pending is cleared on entry to IDLE.
- start while busy is ignored.
- gen_hdr_fire or gen_last_fire in an unexpected state is ignored; no state or counter changes.
- The same-cycle hdr_fire and last_fire case (a 1-byte payload) is not supported by the generator and is not handled.
- Latency:
  - start at cycle t -> gen_enable high at t+1;
  - last_fire at t -> gen_enable low at t+1;
  - re-arm at t+1+max(gap,1).
- rst during a run: immediate return to IDLE, all counters cleared, no done pulse.

Optional Feature:
TEST_PATTERN_SCHED_TIMEOUT_EN
- Defined: a watchdog counts cycles spent in ARM or SEND and reloads on each state entry. On reaching TIMEOUT_CYCLES it forces IDLE, pulses done, and sets a sticky output timeout_err (1 bit, cleared only by rst or an accepted start). The port exists only when the macro is defined.
- Undefined: no watchdog and no timeout_err port; ARM/SEND wait indefinitely.

Decomposition:
- Package test_pattern_pkg: state enum (IDLE, ARM, SEND, GAP), default widths, TS_WIDTH = 24.
- One sub-module, test_pattern_timestamp (prescaler plus wrapping counter). It is reusable by the checker side.
- The FSM, counters and watchdog stay in the top module.

Test Plan:
- Basic run: cfg_packet_count=3, gap=10, generator model with hdr_fire 2 cycles after enable and last_fire 64 cycles later -> 3 enable windows; packet_index 0->1->2->3; sent_count=3; done pulses once; busy falls with done.
- Gap edge: gap=0 vs gap=1 -> identical timing; gen_enable low exactly 1 cycle between packets.
- Stop mid-packet: count=0 (unlimited), stop during the 2nd SEND -> 2nd packet completes; sent_count=2; IDLE after the gap; done pulses; no 3rd ARM.
- Wrap: TS_PRESCALE=1, timestamp forced near 24'hFFFFFE -> reads FFFFFF then 000000. Unlimited run of 65537 packets -> packet_index wraps to 0x0001.
- Reset and simultaneous events: rst asserted in SEND -> all outputs 0 next cycle, no done. start+stop in the same IDLE cycle -> stays IDLE. start while busy -> no effect.
- TEST_PATTERN_SCHED_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, hdr_fire never asserted -> IDLE after 100 cycles in ARM; timeout_err=1; done pulse; next accepted start clears timeout_err.
